// File: rtl/x3q16_mem_pkg.sv
// Shared definitions for the x3q16 SPI memory controller: SPI opcodes, FSM states
// and the request record carried in the active/pending slots.
package x3q16_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] MODE_SEQ = 8'h40;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RECOVER,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        reqType;
    logic [15:0] addr;
    logic [15:0] data;
  } memReq_t;

  // Full 48-bit SPI frame: opcode, 24-bit byte address (word address * 2), data word.
  function automatic logic [47:0] buildFrame(input memReq_t r);
    return {r.reqType ? OP_WRITE : OP_READ, 7'b0, r.addr, 1'b0,
            r.reqType ? r.data : 16'h0000};
  endfunction

endpackage

// File: rtl/x3q16_spi_shifter.sv
// SPI mode-0 frame shifter: drives cs_n/SCK/MOSI for a left-aligned frame of up to
// 48 bits and collects the last 16 MISO bits.
module x3q16_spi_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [47:0] frame_i,
  input  logic [5:0]  nbits_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        csN_o,
  output logic        mosi_o,
  output logic        active_o,
  output logic        bitTick_o,
  output logic        done_o,
  output logic [15:0] rxData_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_q;
  logic          sck_q;
  logic [47:0]   shift_q;
  logic [6:0]    halfCnt_q;
  logic [DW-1:0] divCnt_q;
  logic [15:0]   rx_q;
  logic          tick;

  assign tick      = active_q && (divCnt_q == '0);
  assign done_o    = tick && (halfCnt_q == 7'd0);
  assign bitTick_o = tick && sck_q && (halfCnt_q != 7'd0);
  assign sck_o     = sck_q;
  assign csN_o     = ~active_q;
  assign mosi_o    = shift_q[47];
  assign active_o  = active_q;
  assign rxData_o  = rx_q;

  // The first SCK edge comes one clk after cs_n falls; after the last falling edge
  // SCK stays low for a full half-period before the frame is closed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      sck_q     <= 1'b0;
      shift_q   <= '0;
      halfCnt_q <= '0;
      divCnt_q  <= '0;
      rx_q      <= '0;
    end else if (start_i) begin
      active_q  <= 1'b1;
      sck_q     <= 1'b0;
      shift_q   <= frame_i;
      halfCnt_q <= {nbits_i, 1'b0};
      divCnt_q  <= '0;
    end else if (tick) begin
      divCnt_q <= DW'(CLK_DIV - 1);
      if (halfCnt_q == 7'd0) begin
        active_q <= 1'b0;
        shift_q  <= '0;
      end else begin
        halfCnt_q <= halfCnt_q - 7'd1;
        sck_q     <= ~sck_q;
        if (sck_q) begin
          shift_q <= {shift_q[46:0], 1'b0};
        end else begin
          rx_q <= {rx_q[14:0], miso_i};
        end
      end
    end else if (active_q) begin
      divCnt_q <= divCnt_q - DW'(1);
    end
  end

endmodule

// File: rtl/x3q16_spi_mem_ctrl.sv
// Memory-side partner of the x3q16 core: services single-word read/write requests
// from a 23LC1024-style SPI SRAM, with a one-entry pending buffer.
module x3q16_spi_mem_ctrl
  import x3q16_mem_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH = 2,
  parameter int INIT_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_in,
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] REC_INIT = 8'(CS_HIGH - 1);

  state_e      state_q, state_d;
  logic        activeWr_q, activeWr_d;
  memReq_t     pendReq_q, pendReq_d;
  logic        pendValid_q, pendValid_d;
  logic [7:0]  recCnt_q, recCnt_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic [15:0] memIn_q, memIn_d;
  logic        ready_q, ready_d;
  logic        wrDone_q, wrDone_d;
  logic        crit_q, crit_d;

  memReq_t     incoming, launchRec;
  logic        launch, pendTaken;
  logic        shStart, shActive, shBit, shDone;
  logic [47:0] shFrame;
  logic [5:0]  shBits;
  logic [15:0] shRx;

  assign incoming = {request_type, request_address, data_in};

  x3q16_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (shStart),
    .frame_i   (shFrame),
    .nbits_i   (shBits),
    .miso_i    (spi_miso),
    .sck_o     (spi_sck),
    .csN_o     (spi_cs_n),
    .mosi_o    (spi_mosi),
    .active_o  (shActive),
    .bitTick_o (shBit),
    .done_o    (shDone),
    .rxData_o  (shRx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      activeWr_q  <= 1'b0;
      pendReq_q   <= '0;
      pendValid_q <= 1'b0;
      recCnt_q    <= '0;
      bitCnt_q    <= '0;
      memIn_q     <= '0;
      ready_q     <= 1'b0;
      wrDone_q    <= 1'b0;
      crit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      activeWr_q  <= activeWr_d;
      pendReq_q   <= pendReq_d;
      pendValid_q <= pendValid_d;
      recCnt_q    <= recCnt_d;
      bitCnt_q    <= bitCnt_d;
      memIn_q     <= memIn_d;
      ready_q     <= ready_d;
      wrDone_q    <= wrDone_d;
      crit_q      <= crit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    activeWr_d  = activeWr_q;
    pendReq_d   = pendReq_q;
    pendValid_d = pendValid_q;
    recCnt_d    = recCnt_q;
    bitCnt_d    = bitCnt_q;
    memIn_d     = memIn_q;
    ready_d     = 1'b0;
    wrDone_d    = 1'b0;
    crit_d      = 1'b0;
    shStart     = 1'b0;
    shFrame     = '0;
    shBits      = 6'd48;
    launch      = 1'b0;
    pendTaken   = 1'b0;
    launchRec   = pendReq_q;

    case (state_q)
      ST_INIT: begin
        if (!shActive) begin
          shStart = 1'b1;
          shFrame = {OP_WRMR, MODE_SEQ, 32'h0};
          shBits  = 6'd16;
        end else if (shDone) begin
          state_d  = ST_RECOVER;
          recCnt_d = REC_INIT;
        end
      end
      ST_RECOVER: begin
        if (recCnt_q != 8'd0) begin
          recCnt_d = recCnt_q - 8'd1;
        end else if (pendValid_q) begin
          launch    = 1'b1;
          pendTaken = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pendValid_q) begin
          launch    = 1'b1;
          pendTaken = 1'b1;
        end else if (request) begin
          launch    = 1'b1;
          launchRec = incoming;
        end
      end
      ST_CMD: begin
        if (shBit) begin
          if (bitCnt_q == 5'd7) begin
            state_d  = ST_ADDR;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      ST_ADDR: begin
        if (shBit) begin
          if (bitCnt_q == 5'd23) begin
            state_d  = ST_DATA;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (shDone) begin
          state_d = ST_DONE;
          if (activeWr_q) begin
            wrDone_d = 1'b1;
          end else begin
            ready_d = 1'b1;
            memIn_d = shRx;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_RECOVER;
        recCnt_d = REC_INIT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d    = ST_CMD;
      activeWr_d = launchRec.reqType;
      bitCnt_d   = '0;
      shStart    = 1'b1;
      shFrame    = buildFrame(launchRec);
      shBits     = 6'd48;
    end

    if (pendTaken) begin
      pendValid_d = 1'b0;
    end

    // A request not launched directly lands in the pending slot, which counts as
    // free when its entry is being launched this same cycle.
    if (request && !(state_q == ST_IDLE && !pendValid_q)) begin
      if (!pendValid_q || pendTaken) begin
        pendReq_d   = incoming;
        pendValid_d = 1'b1;
      end else begin
        crit_d = 1'b1;
      end
    end
  end

  assign memory_in       = memIn_q;
  assign memory_ready    = ready_q;
  assign write_complete  = wrDone_q;
  assign memory_critical = crit_q;

endmodule

// File: tb/tb_x3q16_spi_mem_ctrl.sv
// Bench for x3q16_spi_mem_ctrl: behavioural 23LC1024 SPI SRAM, MOSI frame and
// core-response scoreboards, directed request sequence.
module tb_x3q16_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] data_in;
  logic [15:0] memory_in;
  logic        memory_ready;
  logic        write_complete;
  logic        memory_critical;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  x3q16_spi_mem_ctrl #(.CLK_DIV(1), .CS_HIGH(2), .INIT_EN(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .request         (request),
    .request_type    (request_type),
    .request_address (request_address),
    .data_in         (data_in),
    .memory_in       (memory_in),
    .memory_ready    (memory_ready),
    .write_complete  (write_complete),
    .memory_critical (memory_critical),
    .spi_sck         (spi_sck),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] data;
  } expRes_t;

  typedef struct {
    logic [47:0] bits;
    int          n;
  } expFrame_t;

  int          testsRun = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          lastReadyCyc = -1;
  int          lastCritCyc = -1;
  int          critCnt = 0;
  expRes_t     expQ[$];
  expFrame_t   expFrames[$];
  bit [15:0]   refMem [0:65535];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] reqFrame(input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic [23:0] byteAddr;
    byteAddr = {7'b0, a, 1'b0};
    return {wr ? 8'h02 : 8'h03, byteAddr, wr ? d : 16'h0000};
  endfunction

  function automatic expFrame_t initFrame();
    expFrame_t f;
    f.bits = 48'h0000_0000_0140;
    f.n    = 16;
    return f;
  endfunction

  // Behavioural SPI SRAM, sequential mode, sampled mid-cycle.
  bit [7:0]    extMem [0:131071];
  logic        prevSck = 1'b0;
  logic        inTxn = 1'b0;
  int          mBits = 0;
  logic [47:0] mFrame = '0;
  logic [7:0]  mCmd = '0;
  logic [23:0] mAddr = '0;
  int          highCnt = 0;
  int          minGap = 1000;
  bit          seenTxn = 1'b0;

  always @(negedge clk) begin
    if (reset || spi_cs_n) begin
      if (inTxn && !reset) begin
        if (expFrames.size() == 0) begin
          checkOutput("unexpected_frame", 64'(mBits), 64'd0);
        end else begin
          expFrame_t f;
          f = expFrames.pop_front();
          checkOutput("frame_bits", mFrame, f.bits);
          checkOutput("frame_len", 64'(mBits), 64'(f.n));
        end
      end
      inTxn    = 1'b0;
      highCnt++;
      spi_miso = 1'b0;
    end else begin
      if (!inTxn) begin
        inTxn  = 1'b1;
        mBits  = 0;
        mFrame = '0;
        mCmd   = '0;
        if (seenTxn && highCnt < minGap) minGap = highCnt;
        seenTxn = 1'b1;
        highCnt = 0;
      end
      if (spi_sck && !prevSck) begin
        mFrame = {mFrame[46:0], spi_mosi};
        mBits++;
        if (mBits == 8) mCmd = mFrame[7:0];
        if (mBits == 32) mAddr = mFrame[23:0];
        if (mCmd == 8'h02 && mBits >= 40 && (mBits % 8) == 0)
          extMem[(int'(mAddr) + (mBits - 40) / 8) & 32'h1FFFF] = mFrame[7:0];
      end else if (!spi_sck && prevSck && mCmd == 8'h03 && mBits >= 32) begin
        spi_miso = extMem[(int'(mAddr) + (mBits - 32) / 8) & 32'h1FFFF][7 - ((mBits - 32) % 8)];
      end
    end
    prevSck = spi_sck;
  end

  // Core-side response monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (memory_ready || write_complete) begin
        checkOutput("pulse_overlap", {63'd0, memory_ready & write_complete}, 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", {62'd0, memory_ready, write_complete}, 64'd0);
        end else begin
          expRes_t e;
          e = expQ.pop_front();
          checkOutput("pulse_type", {63'd0, write_complete}, {63'd0, e.wr});
          if (!e.wr) checkOutput("read_data", memory_in, e.data);
        end
      end
      if (memory_ready) lastReadyCyc = cyc;
      if (memory_critical) begin
        critCnt++;
        lastCritCyc = cyc;
      end
    end
  end

  task automatic alignEdge();
    @(posedge clk);
    #1;
  endtask

  // Drives one request cycle; call at posedge+1, returns at the next posedge+1.
  task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [15:0] d,
                               input bit accept, output int reqCyc);
    expRes_t   e;
    expFrame_t f;
    request         = 1'b1;
    request_type    = wr;
    request_address = a;
    data_in         = d;
    reqCyc          = cyc;
    if (accept) begin
      e.wr   = wr;
      e.data = refMem[a];
      f.bits = reqFrame(wr, a, d);
      f.n    = 48;
      expQ.push_back(e);
      expFrames.push_back(f);
      if (wr) refMem[a] = d;
    end
    @(posedge clk);
    #1;
    request = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || expFrames.size() != 0) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(expQ.size() + expFrames.size()), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int t;
    int t3;
    int critBefore;
    reset           = 1'b1;
    request         = 1'b0;
    request_type    = 1'b0;
    request_address = '0;
    data_in         = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
    checkOutput("rst_sck", {63'd0, spi_sck}, 64'd0);
    checkOutput("rst_mosi", {63'd0, spi_mosi}, 64'd0);
    checkOutput("rst_memory_in", memory_in, 64'd0);
    checkOutput("rst_pulses", {61'd0, memory_ready, write_complete, memory_critical}, 64'd0);

    // Request held in the first post-reset cycle: WRMR must precede the read.
    reset = 1'b0;
    expFrames.push_back(initFrame());
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, t);
    waitDrain(400);

    // Write then read back-to-back (second goes to the pending slot).
    alignEdge();
    applyStimulus(1'b1, 16'h0010, 16'h1234, 1'b1, t);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b1, t);
    waitDrain(500);

    // Idle read latency.
    alignEdge();
    applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b1, t);
    waitDrain(300);
    checkOutput("read_latency", 64'(lastReadyCyc - t), 64'd98);

    // Three consecutive requests: third one overflows.
    critBefore = critCnt;
    alignEdge();
    applyStimulus(1'b1, 16'h0100, 16'hAAAA, 1'b1, t);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b1, t);
    applyStimulus(1'b1, 16'h0200, 16'h5555, 1'b0, t3);
    waitDrain(600);
    checkOutput("crit_count", 64'(critCnt - critBefore), 64'd1);
    checkOutput("crit_cycle", 64'(lastCritCyc), 64'(t3 + 1));
    alignEdge();
    applyStimulus(1'b0, 16'h0200, 16'h0000, 1'b1, t);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 1'b1, t);
    waitDrain(600);

    // Reset in the middle of the address phase.
    alignEdge();
    applyStimulus(1'b0, 16'h0100, 16'h0000, 1'b1, t);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_cs_n", {63'd0, spi_cs_n}, 64'd1);
    checkOutput("midrst_sck", {63'd0, spi_sck}, 64'd0);
    checkOutput("midrst_memory_in", memory_in, 64'd0);
    checkOutput("midrst_pulses", {61'd0, memory_ready, write_complete, memory_critical}, 64'd0);
    expQ.delete();
    expFrames.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expFrames.push_back(initFrame());
    waitDrain(200);
    alignEdge();
    applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b1, t);
    waitDrain(300);

    // Top word address maps to byte address 0x1FFFE.
    alignEdge();
    applyStimulus(1'b1, 16'hFFFF, 16'hBEEF, 1'b1, t);
    applyStimulus(1'b0, 16'hFFFF, 16'h0000, 1'b1, t);
    waitDrain(500);
    checkOutput("hi_byte_mem", {56'd0, extMem[17'h1FFFE]}, 64'hBE);

    checkOutput("cs_gap_ok", {63'd0, (minGap >= 2 && minGap < 1000)}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
